spi_byte_rx: RTL and testbench

SPI slave front end that feeds the control unit's byte stream. It oversamples an external mode-0 SPI bus in the `clk` domain and assembles MOSI bits into bytes. Received bytes are buffered in a first-word-fall-through FIFO, which the control unit drains one byte per `next` pulse. In the same transfer it shifts the control unit's status byte (`tx_byte`) back out on MISO.

---
 rtl/spi_byte_rx_pkg.sv | 23 ++
 rtl/spi_byte_rx_byte_fifo.sv | 62 ++++++
 rtl/spi_byte_rx.sv | 179 +++++++++++++++++
 tb/tb_spi_byte_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_rx_pkg.sv
// spi_byte_rx shared definitions.
// Byte width, default FIFO depth, synchronizer idle levels, FSM states.
package spi_byte_rx_pkg;

    localparam int SPI_BYTE_WIDTH     = 8;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic CS_N_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    typedef logic [SPI_BYTE_WIDTH-1:0] byte_t;

    // FLUSH lets the synchronizers refill after reset, WAIT needs cs_n
    // seen high so a frame cut by reset is never resumed mid-byte.
    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_WAIT,
        ST_IDLE,
        ST_ACTIVE
    } rx_state_e;

endpackage

// File: rtl/spi_byte_rx_byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte FIFO.
// Pop while empty is ignored; push while full succeeds only with a pop.
module byte_fifo
    import spi_byte_rx_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  byte_t         din,
    output byte_t         dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    byte_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Qualify requests and advance pointers/count.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: oversampled mode-0 SPI slave with receive FIFO.
// Bytes from MOSI are queued; the status byte is returned on MISO.
module spi_byte_rx
    import spi_byte_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic [7:0]  out_byte,
    output logic        out_ready,
    input  logic        next,
    input  logic [7:0]  tx_byte,
    output logic        frame_active,
    output logic        overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_dly_q, sck_dly_d;
    logic                   cs_dly_q, cs_dly_d;

    rx_state_e     state_q, state_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    byte_t         rx_shift_q, rx_shift_d;
    byte_t         tx_shift_q, tx_shift_d;
    logic          done_q, done_d;
    logic          push_q, push_d;

    logic          sck_s, cs_s, mosi_s;
    logic          sck_rise, sck_fall;
    logic          cs_rise, cs_fall;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s && !sck_dly_q;
    assign sck_fall = !sck_s && sck_dly_q;
    assign cs_rise  = cs_s && !cs_dly_q;
    assign cs_fall  = !cs_s && cs_dly_q;

    // Shift pads into the synchronizer chains and edge-detect copies.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_dly_d   = sck_s;
        cs_dly_d    = cs_s;
    end

    // Synchronizer registers, reset to bus idle levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q  <= {SYNC_STAGES{SCK_IDLE}};
            cs_sync_q   <= {SYNC_STAGES{CS_N_IDLE}};
            mosi_sync_q <= {SYNC_STAGES{MOSI_IDLE}};
            sck_dly_q   <= SCK_IDLE;
            cs_dly_q    <= CS_N_IDLE;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_dly_q   <= sck_dly_d;
            cs_dly_q    <= cs_dly_d;
        end
    end

    // Frame FSM, bit counter and both shift registers.
    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        done_d     = done_q;
        push_d     = 1'b0;
        unique case (state_q)
            ST_FLUSH: begin
                if (flush_q == FW'(SYNC_STAGES - 1)) begin
                    state_d = ST_WAIT;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            ST_WAIT: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = '0;
                    tx_shift_d = tx_byte;
                    done_d     = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d    = ST_IDLE;
                    bit_cnt_d  = '0;
                    tx_shift_d = '0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        push_d    = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0 && done_q) begin
                        tx_shift_d = tx_byte;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    // Frame state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FLUSH;
            flush_q    <= '0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            done_q     <= 1'b0;
            push_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            done_q     <= done_d;
            push_q     <= push_d;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pop   (next),
        .din   (rx_shift_q),
        .dout  (out_byte),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign out_ready    = (fifo_count != '0);
    assign miso         = (state_q == ST_ACTIVE) && tx_shift_q[7];
    assign frame_active = !cs_dly_q;
    assign overflow     = push_q && fifo_full && !(next && !fifo_empty);

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: SCK at clk/8, immediate-assert checks.
// Covers reset, latency, MISO reload, partial byte, overflow, reset, pops.
module tb_spi_byte_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       next = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       miso;
    logic [7:0] out_byte;
    logic       out_ready;
    logic       frame_active;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int ovf_cnt = 0;

    spi_byte_rx #(
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sck          (sck),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .out_byte     (out_byte),
        .out_ready    (out_ready),
        .next         (next),
        .tx_byte      (tx_byte),
        .frame_active (frame_active),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic frame_end();
        tick(4);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic pop();
        next = 1'b1;
        tick(1);
        next = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] data, input int nbits,
                             input bit pop_on_push,
                             output logic [7:0] rx_miso, output int lat);
        rx_miso = 8'h00;
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            mosi = data[7-i];
            tick(4);
            sck = 1'b1;
            rx_miso = {rx_miso[6:0], miso};
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                #1;
                if (next) next = 1'b0;
                if (i == 7 && lat == 0 && out_ready) lat = k;
                if (i == 7 && pop_on_push && k == 3) begin
                    next = 1'b1;
                    #1;
                    check("ovf_with_pop", overflow, 1'b0);
                end
            end
            sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] data);
        logic [7:0] m;
        int l;
        send_bits(data, 8, 1'b0, m, l);
    endtask

    initial begin
        logic [7:0] m1;
        logic [7:0] m2;
        int lat;

        tick(3);
        check("rst_miso", miso, 1'b0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_out_ready", out_ready, 1'b0);
        check("rst_frame_active", frame_active, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b0;
        tick(6);

        tx_byte = 8'h00;
        frame_begin();
        check("frame_active_on", frame_active, 1'b1);
        send_bits(8'hA5, 8, 1'b0, m1, lat);
        check("rx_latency", 8'(lat), 8'd4);
        frame_end();
        check("single_ready", out_ready, 1'b1);
        check("single_byte", out_byte, 8'hA5);
        pop();
        check("single_popped", out_ready, 1'b0);
        check("frame_active_off", frame_active, 1'b0);

        tx_byte = 8'h3C;
        frame_begin();
        fork
            send_bits(8'h10, 8, 1'b0, m1, lat);
            begin
                tick(20);
                tx_byte = 8'h81;
            end
        join
        send_bits(8'h20, 8, 1'b0, m2, lat);
        frame_end();
        check("miso_byte1", m1, 8'h3C);
        check("miso_byte2", m2, 8'h81);
        check("miso_rx1", out_byte, 8'h10);
        pop();
        check("miso_rx2", out_byte, 8'h20);
        pop();
        check("miso_empty", out_ready, 1'b0);

        tx_byte = 8'h00;
        frame_begin();
        send_bits(8'hA8, 5, 1'b0, m1, lat);
        frame_end();
        check("partial_dropped", out_ready, 1'b0);
        frame_begin();
        send_byte(8'h7E);
        frame_end();
        check("realign_ready", out_ready, 1'b1);
        check("realign_byte", out_byte, 8'h7E);
        pop();
        check("realign_empty", out_ready, 1'b0);

        frame_begin();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
        check("ovf_none_16", 8'(ovf_cnt), 8'd0);
        send_byte(8'h40);
        check("ovf_one_17", 8'(ovf_cnt), 8'd1);
        check("ovf_head", out_byte, 8'h30);
        send_bits(8'hC3, 8, 1'b1, m1, lat);
        check("ovf_still_one", 8'(ovf_cnt), 8'd1);
        frame_end();
        for (int i = 1; i < 16; i++) begin
            check("drain_byte", out_byte, 8'(8'h30 + i));
            pop();
        end
        check("drain_last", out_byte, 8'hC3);
        pop();
        check("drain_empty", out_ready, 1'b0);

        tx_byte = 8'hFF;
        frame_begin();
        send_byte(8'h11);
        send_bits(8'hE0, 3, 1'b0, m1, lat);
        reset = 1'b1;
        tick(2);
        check("mrst_empty", out_ready, 1'b0);
        check("mrst_miso", miso, 1'b0);
        reset = 1'b0;
        send_bits(8'hF8, 5, 1'b0, m1, lat);
        send_bits(8'h66, 8, 1'b0, m2, lat);
        check("mrst_miso_tail", m1, 8'h00);
        check("mrst_miso_next", m2, 8'h00);
        frame_end();
        check("mrst_ignored", out_ready, 1'b0);
        frame_begin();
        send_byte(8'h55);
        frame_end();
        check("mrst_new_byte", out_byte, 8'h55);
        pop();
        check("mrst_new_empty", out_ready, 1'b0);

        pop();
        check("epop_ready", out_ready, 1'b0);
        check("epop_byte", out_byte, 8'h00);
        frame_begin();
        send_byte(8'h9A);
        frame_end();
        check("epop_rx_ready", out_ready, 1'b1);
        check("epop_rx_byte", out_byte, 8'h9A);
        pop();
        check("epop_rx_empty", out_ready, 1'b0);
        frame_begin();
        send_byte(8'h42);
        frame_end();
        check("epop_ptr_byte", out_byte, 8'h42);
        pop();
        check("epop_ptr_empty", out_ready, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
